ser2par_keep_rx: RTL and testbench

- Serial-to-parallel receiver, LSB first, for the team's KEEP-stretched serial link.
- Each serial bit is presented with valid high for exactly KEEP consecutive cycles. The block samples each bit window, reassembles DATAWIDTH bits into a word, and hands the word downstream over a valid/ready handshake.
- Sits at the far end of the serial link, facing the parallel consumer.

---
 rtl/ser2par_keep_rx.sv | 135 +++++++++++++
 tb/tb_ser2par_keep_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_keep_rx.sv
// ser2par_keep_rx
//   LSB-first serial-to-parallel receiver for a KEEP-stretched serial link.
//   Every serial bit is held with valid high for KEEP consecutive cycles.
//   The receiver checks each bit window for glitches and takes the bit value
//   from the sample at window cycle KEEP/2. After DATAWIDTH bits it offers the
//   word downstream over a valid/ready handshake.
//
// Ports
//   clk             rising-edge clock
//   rstn            asynchronous active-low reset
//   i_DataIn        serial data bit
//   i_DataInValid   high while i_DataIn carries a frame bit
//   o_DataOut       assembled word, bit 0 = first bit received
//   o_DataOutValid  o_DataOut holds an unconsumed word
//   i_DataOutReady  downstream accepts when high with o_DataOutValid
//   o_DataErr       a glitch was seen inside some bit window of o_DataOut
//   o_FrameError    1-cycle pulse: valid dropped before the word completed
//   o_Overrun       1-cycle pulse: completed word dropped, output still full
module ser2par_keep_rx #(
    parameter int DATAWIDTH = 8,
    parameter int KEEP      = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_DataIn,
    input  logic                 i_DataInValid,
    output logic [DATAWIDTH-1:0] o_DataOut,
    output logic                 o_DataOutValid,
    input  logic                 i_DataOutReady,
    output logic                 o_DataErr,
    output logic                 o_FrameError,
    output logic                 o_Overrun
);

    localparam int KW = (KEEP > 1) ? $clog2(KEEP) : 1;
    localparam int BW = $clog2(DATAWIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(KEEP - 1);
    localparam logic [KW-1:0] K_MID  = KW'(KEEP / 2);
    localparam logic [BW-1:0] B_LAST = BW'(DATAWIDTH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t               r_State;
    logic [DATAWIDTH-1:0] r_Shift;
    logic [KW-1:0]        r_KeepCnt;
    logic [BW-1:0]        r_BitCnt;
    logic                 r_Glitch;
    logic                 r_Ref;
    logic                 r_Sample;

    logic                 w_Mismatch;
    logic                 w_Bit;
    logic                 w_OutFree;
    logic [DATAWIDTH-1:0] w_Word;

    // Window cycle 0 defines the reference, so only later cycles can glitch.
    assign w_Mismatch = (r_KeepCnt != '0) && (i_DataIn != r_Ref);
    // When the middle sample is the current cycle (small KEEP) take it live.
    assign w_Bit      = (r_KeepCnt == K_MID) ? i_DataIn : r_Sample;
    // A handshake this cycle frees the output register for a new load.
    assign w_OutFree  = !o_DataOutValid || i_DataOutReady;

    always_comb begin
        w_Word           = r_Shift;
        w_Word[r_BitCnt] = w_Bit;
    end

    // S_IDLE holds both counters at 0, so a valid cycle there is handled
    // exactly like window cycle 0 of bit 0 in S_SHIFT. The states differ only
    // in how a low valid is treated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_State        <= S_IDLE;
            r_Shift        <= '0;
            r_KeepCnt      <= '0;
            r_BitCnt       <= '0;
            r_Glitch       <= 1'b0;
            r_Ref          <= 1'b0;
            r_Sample       <= 1'b0;
            o_DataOut      <= '0;
            o_DataOutValid <= 1'b0;
            o_DataErr      <= 1'b0;
            o_FrameError   <= 1'b0;
            o_Overrun      <= 1'b0;
        end else begin
            o_FrameError <= 1'b0;
            o_Overrun    <= 1'b0;
            if (o_DataOutValid && i_DataOutReady)
                o_DataOutValid <= 1'b0;

            if (i_DataInValid) begin
                if (r_KeepCnt == '0)
                    r_Ref <= i_DataIn;
                if (r_KeepCnt == K_MID)
                    r_Sample <= i_DataIn;

                if (r_KeepCnt == K_LAST) begin
                    r_KeepCnt <= '0;
                    if (r_BitCnt == B_LAST) begin
                        // Word complete: next valid cycle starts a new word.
                        r_State  <= S_IDLE;
                        r_BitCnt <= '0;
                        r_Shift  <= '0;
                        r_Glitch <= 1'b0;
                        if (w_OutFree) begin
                            o_DataOut      <= w_Word;
                            o_DataErr      <= r_Glitch | w_Mismatch;
                            o_DataOutValid <= 1'b1;
                        end else begin
                            o_Overrun <= 1'b1;
                        end
                    end else begin
                        r_State  <= S_SHIFT;
                        r_Shift  <= w_Word;
                        r_BitCnt <= r_BitCnt + 1'b1;
                        r_Glitch <= r_Glitch | w_Mismatch;
                    end
                end else begin
                    r_State   <= S_SHIFT;
                    r_KeepCnt <= r_KeepCnt + 1'b1;
                    r_Glitch  <= r_Glitch | w_Mismatch;
                end
            end else if (r_State == S_SHIFT) begin
                // Valid dropped mid-word: abort the frame.
                o_FrameError <= 1'b1;
                r_State      <= S_IDLE;
                r_Shift      <= '0;
                r_KeepCnt    <= '0;
                r_BitCnt     <= '0;
                r_Glitch     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ser2par_keep_rx.sv
// Testbench for ser2par_keep_rx (DATAWIDTH=8, KEEP=3).
// Inputs change 1 ns after the rising edge; the monitor samples on the
// falling edge, direct checks read outputs 1 ns after the rising edge.
module tb_ser2par_keep_rx;

    localparam int DW   = 8;
    localparam int KEEP = 3;

    logic          clk;
    logic          rstn;
    logic          i_DataIn;
    logic          i_DataInValid;
    logic [DW-1:0] o_DataOut;
    logic          o_DataOutValid;
    logic          i_DataOutReady;
    logic          o_DataErr;
    logic          o_FrameError;
    logic          o_Overrun;

    ser2par_keep_rx #(.DATAWIDTH(DW), .KEEP(KEEP)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_DataIn       (i_DataIn),
        .i_DataInValid  (i_DataInValid),
        .o_DataOut      (o_DataOut),
        .o_DataOutValid (o_DataOutValid),
        .i_DataOutReady (i_DataOutReady),
        .o_DataErr      (o_DataErr),
        .o_FrameError   (o_FrameError),
        .o_Overrun      (o_Overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor: record accepted words, pulse counts and cycle stamps.
    int            cyc      = 0;
    int            fe_cnt   = 0;
    int            ov_cnt   = 0;
    int            both_cnt = 0;
    logic [DW-1:0] rx_d[$];
    logic          rx_e[$];
    int            rx_c[$];

    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (o_FrameError) fe_cnt++;
            if (o_Overrun) ov_cnt++;
            if (o_FrameError && o_Overrun) both_cnt++;
            if (o_DataOutValid && i_DataOutReady) begin
                rx_d.push_back(o_DataOut);
                rx_e.push_back(o_DataErr);
                rx_c.push_back(cyc);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rx_clear();
        rx_d.delete();
        rx_e.delete();
        rx_c.delete();
    endtask

    // Drive one word, optionally inverting a single sample (gbit, gcyc).
    // Leaves valid high on the last sample; caller decides what follows.
    task automatic send_word(input logic [DW-1:0] d, input int gbit, input int gcyc);
        for (int b = 0; b < DW; b++) begin
            for (int c = 0; c < KEEP; c++) begin
                @(posedge clk); #1;
                i_DataInValid = 1'b1;
                i_DataIn      = d[b] ^ ((b == gbit) && (c == gcyc));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_DataInValid = 1'b0;
            i_DataIn      = 1'b0;
        end
    endtask

    // Reference: a word's bits come from the middle sample of each window;
    // any inverted sample inside a window (KEEP > 1) flags the word.
    function automatic logic [DW:0] model(input logic [DW-1:0] d, input int gbit, input int gcyc);
        logic [DW-1:0] w;
        logic          e;
        w = d;
        e = 1'b0;
        if (gbit >= 0) begin
            if (gcyc == KEEP / 2) w[gbit] = ~w[gbit];
            e = (KEEP > 1);
        end
        return {e, w};
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            gbit;
        int            gcyc;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    vec_t vt[7];

    initial begin
        int fe0;
        int ov0;
        int n;
        logic [DW-1:0] exp_d[$];
        logic          exp_e[$];

        vt[0] = '{8'h15, -1, -1, 8'h15, 1'b0};
        vt[1] = '{8'hA5,  3,  0, 8'hA5, 1'b1};
        vt[2] = '{8'hA5,  0,  1, 8'hA4, 1'b1};
        vt[3] = '{8'h00,  7,  2, 8'h00, 1'b1};
        vt[4] = '{8'hFF, -1, -1, 8'hFF, 1'b0};
        vt[5] = '{8'h80,  7,  1, 8'h00, 1'b1};
        vt[6] = '{8'h01,  0,  0, 8'h01, 1'b1};

        rstn           = 1'b0;
        i_DataIn       = 1'b0;
        i_DataInValid  = 1'b0;
        i_DataOutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_DataOutValid, 0);
        chk("rst_data", o_DataOut, 0);
        chk("rst_err", o_DataErr, 0);
        chk("rst_fe", o_FrameError, 0);
        chk("rst_ov", o_Overrun, 0);
        rstn = 1'b1;
        idle(2);

        // Table-driven single words, ready held high.
        for (int i = 0; i < 7; i++) begin
            send_word(vt[i].data, vt[i].gbit, vt[i].gcyc);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), o_DataOutValid, 1);
            chk($sformatf("vec%0d_data", i), o_DataOut, vt[i].exp_data);
            chk($sformatf("vec%0d_err", i), o_DataErr, vt[i].exp_err);
            i_DataInValid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_fall", i), o_DataOutValid, 0);
            idle(1);
        end

        // Back-to-back words, no valid gap.
        rx_clear();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_word(8'h35, -1, -1);
        send_word(8'h12, -1, -1);
        idle(3);
        chk("b2b_count", rx_d.size(), 2);
        if (rx_d.size() == 2) begin
            chk("b2b_w0", rx_d[0], 8'h35);
            chk("b2b_w1", rx_d[1], 8'h12);
            chk("b2b_spacing", rx_c[1] - rx_c[0], 24);
            chk("b2b_err", {rx_e[0], rx_e[1]}, 0);
        end
        chk("b2b_fe", fe_cnt - fe0, 0);
        chk("b2b_ov", ov_cnt - ov0, 0);

        // Frame abort after 10 valid cycles, then a clean word.
        rx_clear();
        fe0 = fe_cnt;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            i_DataInValid = 1'b1;
            i_DataIn      = k[0];
        end
        @(posedge clk); #1;
        i_DataInValid = 1'b0;
        @(posedge clk); #1;
        chk("fe_pulse", o_FrameError, 1);
        idle(3);
        chk("fe_count", fe_cnt - fe0, 1);
        chk("fe_noword", rx_d.size(), 0);
        send_word(8'h3C, -1, -1);
        idle(2);
        chk("fe_next_count", rx_d.size(), 1);
        if (rx_d.size() == 1) chk("fe_next_word", {rx_e[0], rx_d[0]}, {1'b0, 8'h3C});

        // Overrun: ready low, two words, second dropped.
        rx_clear();
        ov0 = ov_cnt;
        i_DataOutReady = 1'b0;
        send_word(8'h11, -1, -1);
        send_word(8'h22, -1, -1);
        @(posedge clk); #1;
        chk("ov_pulse", o_Overrun, 1);
        chk("ov_held", o_DataOut, 8'h11);
        chk("ov_valid", o_DataOutValid, 1);
        i_DataInValid = 1'b0;
        @(posedge clk); #1;
        chk("ov_pulse_end", o_Overrun, 0);
        chk("ov_stable", o_DataOut, 8'h11);
        i_DataOutReady = 1'b1;
        @(posedge clk); #1;
        chk("ov_fall", o_DataOutValid, 0);
        chk("ov_count", ov_cnt - ov0, 1);
        chk("ov_accepted", rx_d.size(), 1);
        if (rx_d.size() == 1) chk("ov_acc_word", rx_d[0], 8'h11);

        // Reset mid-frame with a word pending.
        i_DataOutReady = 1'b0;
        send_word(8'h5A, -1, -1);
        idle(1);
        chk("rm_pending", o_DataOutValid, 1);
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            i_DataInValid = 1'b1;
            i_DataIn      = 1'b1;
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rm_valid", o_DataOutValid, 0);
        chk("rm_data", o_DataOut, 0);
        chk("rm_err", o_DataErr, 0);
        i_DataInValid  = 1'b0;
        @(posedge clk); #1;
        rx_clear();
        fe0 = fe_cnt;
        rstn           = 1'b1;
        i_DataOutReady = 1'b1;
        idle(2);
        send_word(8'h7E, -1, -1);
        idle(2);
        chk("rm_fe", fe_cnt - fe0, 0);
        chk("rm_count", rx_d.size(), 1);
        if (rx_d.size() == 1) chk("rm_word", {rx_e[0], rx_d[0]}, {1'b0, 8'h7E});

        // Randomized stream with gaps and occasional glitches.
        rx_clear();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int w = 0; w < 30; w++) begin
            logic [DW-1:0] d;
            logic [DW:0]   m;
            int            gb;
            int            gc;
            d  = DW'($urandom);
            gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DW - 1)) : -1;
            gc = int'($urandom_range(0, KEEP - 1));
            m  = model(d, gb, gc);
            exp_d.push_back(m[DW-1:0]);
            exp_e.push_back(m[DW]);
            send_word(d, gb, gc);
            n = int'($urandom_range(0, 2));
            if (n > 0) idle(n);
        end
        idle(3);
        chk("rnd_count", rx_d.size(), exp_d.size());
        n = (rx_d.size() < exp_d.size()) ? rx_d.size() : exp_d.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("rnd_word%0d", i), {rx_e[i], rx_d[i]}, {exp_e[i], exp_d[i]});
        chk("rnd_fe", fe_cnt - fe0, 0);
        chk("rnd_ov", ov_cnt - ov0, 0);
        chk("excl_fe_ov", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
